mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store data path between the MEM pipeline stage and a word-only data memory.
- Loads: reads a word, selects the byte or halfword lane, then sign- or zero-extends it to 32 bits. This is the extension on the read side of memory, counterpart to the immediate extender on the instruction side.
- Sub-word stores: performs a read-modify-write, merging the byte or halfword into the existing word.
- Multi-cycle with a req/done handshake; the pipeline stalls while busy=1.

Parameters:
- MEM_AW, 12, word-address width of the data memory (4·2^MEM_AW bytes).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = store, 0 = load.
- op  in  3  access type: 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned. For stores, 001/010 both mean half and 011/100 both mean byte. Codes 101-111 are illegal.
- addr  in  32  byte address.
- wdata  in  32  store data; the low 8 or 16 bits are used for sub-word stores.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result.
- addr_err  out  1  misaligned access or illegal op; valid while done=1.
- mem_addr  out  MEM_AW  word address, equal to the captured addr[MEM_AW+1:2].
- mem_re  out  1  memory read strobe.
- mem_rdata  in  32  read data, valid the cycle after mem_re.
- mem_we  out  1  memory write strobe; the word is written at the rising edge.
- mem_wdata  out  32  write data.

Behaviour:
- Reset: state = IDLE. busy, done, addr_err, mem_re and mem_we are 0. rdata, mem_wdata and the internal captured registers are 0.
- Reset is asynchronous and takes effect mid-operation. An in-flight write is abandoned, and mem_we falls immediately.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]=k. The halfword at addr[1]=h occupies bits [16h+15:16h].
- Alignment:
  - word: addr[1:0] must be 00.
  - half: addr[0] must be 0.
  - byte: any address is aligned.
- Address bits above MEM_AW+1 are ignored (the address wraps).
- Accept: in IDLE with req=1, the unit captures we, op, addr and wdata at the edge and clears addr_err. req is ignored in every other state.
- Next state after accept:
  - misaligned or illegal op → ERR.
  - store word → WR.
  - otherwise → RD.
- FSM:
  - ERR: sets addr_err; → DONE. No memory strobe is asserted.
  - RD: mem_re=1; → MRG.
  - MRG: latches mem_rdata.
    - Load: rdata ← lane extracted and extended (signed ops replicate bit 7 or bit 15; unsigned ops zero-fill; word loads pass through); → DONE.
    - Sub-word store: merge register ← mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0]; → WR.
  - WR: mem_we=1. mem_wdata = captured wdata for a word store, or the merged word for a sub-word store; → DONE.
  - DONE: done=1 for exactly one cycle; → IDLE.
- mem_re and mem_we are never high in the same cycle.
- mem_addr is held constant from RD or WR through DONE.
- Latency from accept edge to done high, counted in edges: store word 2, load 3, sub-word store 4, error 2.
- rdata holds its value until the next successful load reaches MRG. Stores and errors do not change rdata.
- addr_err holds its value until the next accept.
- A request asserted in the DONE cycle is ignored. It is accepted once the unit is back in IDLE, so back-to-back requests have one idle cycle between them.

Test Plan:
- Memory word at 0x10 = 0x8899AABB.
  - lb at 0x11 → rdata 0xFFFFFFAA.
  - lbu at 0x11 → 0x000000AA.
  - lh at 0x12 → 0xFFFF8899.
  - lhu at 0x12 → 0x00008899.
  - Each has done 3 edges after accept.
- sb at 0x13 with wdata=0x12345677 → sequence RD, MRG, WR; memory word at 0x10 becomes 0x7799AABB; done 4 edges after accept; rdata unchanged.
- sh at 0x12 with wdata=0xFFFFBEEF → word becomes 0xBEEFAABB. sw at 0x14 with wdata=0xDEADBEEF → mem_re never asserted; done after 2 edges; lw at 0x14 returns 0xDEADBEEF.
- Error cases:
  - lh at 0x11 → addr_err=1 with done after 2 edges, no mem_re or mem_we.
  - op=110 at 0x10 → addr_err=1.
  - A following valid lw clears addr_err.
- Reset asserted during WR of sb at 0x13 → mem_we drops without waiting for an edge; memory word at 0x10 is unchanged; busy=0 and all outputs are 0; the next request completes normally.
- req held high continuously with alternating lw/sw → each access completes with exactly one done pulse; captured fields do not change while busy=1 even if inputs toggle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word loads are lane-selected and extended; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  localparam int unsigned CAP_AW = MEM_AW + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    RD   = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [2:0] OP_W   = 3'd0;
  localparam logic [2:0] OP_HS  = 3'd1;
  localparam logic [2:0] OP_HU  = 3'd2;
  localparam logic [2:0] OP_BS  = 3'd3;
  localparam logic [2:0] OP_BU  = 3'd4;

  state_t              state, state_d;
  logic                we_q;
  logic [2:0]          op_q;
  logic [CAP_AW-1:0]   addr_q;
  logic [15:0]         wdata_q;

  logic                cap;
  logic                bad;
  logic                err_d;
  logic [31:0]         rdata_d;
  logic [31:0]         mem_wdata_d;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_val;
  logic [31:0]         merged;

  // Address bits above the memory window are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:CAP_AW];

  assign mem_addr = addr_q[CAP_AW-1:2];

  // Illegal op or misalignment, judged on the request inputs at accept time.
  always_comb begin
    bad = 1'b0;
    if (op > OP_BU)
      bad = 1'b1;
    else if (op == OP_W && addr[1:0] != 2'b00)
      bad = 1'b1;
    else if ((op == OP_HS || op == OP_HU) && addr[0])
      bad = 1'b1;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_HS:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_val = {16'h0000, half_sel};
      OP_BS:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_val = {24'h000000, byte_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (op_q == OP_BS || op_q == OP_BU)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d     = state;
    cap         = 1'b0;
    err_d       = addr_err;
    rdata_d     = rdata;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (req) begin
          cap   = 1'b1;
          err_d = 1'b0;
          if (bad) begin
            state_d = ERR;
          end else if (we && op == OP_W) begin
            state_d     = WR;
            mem_wdata_d = wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = DONE;
      end
      RD:  state_d = MRG;
      MRG: begin
        if (we_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      addr_err  <= 1'b0;
      rdata     <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state <= state_d;
      if (cap) begin
        we_q    <= we;
        op_q    <= op;
        addr_q  <= addr[CAP_AW-1:0];
        wdata_q <= wdata[15:0];
      end
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      mem_re    <= (state_d == RD);
      mem_we    <= (state_d == WR);
      addr_err  <= err_d;
      rdata     <= rdata_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a synchronous word memory model.
module tb_mem_access_unit;

  localparam int unsigned MEM_AW = 12;

  logic              clk;
  logic              reset;
  logic              req;
  logic              we;
  logic [2:0]        op;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              addr_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
  end

  task automatic access(input logic w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int nre, output int nwe);
    @(negedge clk);
    we = w; op = o; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 1; nre = 0; nwe = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nre += int'(mem_re);
      nwe += int'(mem_we);
      if (done) break;
      @(posedge clk);
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic load(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] exp);
    int lat, nre, nwe;
    access(1'b0, o, a, 32'h0, lat, nre, nwe);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_err"}, 32'(addr_err), 32'd0);
  endtask

  int lat, nre, nwe;
  int idx, extra, prev_done;
  logic        s_we    [4];
  logic [31:0] s_addr  [4];
  logic [31:0] s_data  [4];

  initial begin
    req = 1'b0; we = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_maddr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Preload word 0x10 with a word store.
    access(1'b1, 3'd0, 32'h10, 32'h8899AABB, lat, nre, nwe);
    check("pre_mem", mem[4], 32'h8899AABB);

    load("lb",  3'd3, 32'h11, 32'hFFFFFFAA);
    load("lbu", 3'd4, 32'h11, 32'h000000AA);
    load("lh",  3'd1, 32'h12, 32'hFFFF8899);
    load("lhu", 3'd2, 32'h12, 32'h00008899);

    access(1'b1, 3'd3, 32'h13, 32'h12345677, lat, nre, nwe);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_re", 32'(nre), 32'd1);
    check("sb_we", 32'(nwe), 32'd1);
    check("sb_mem", mem[4], 32'h7799AABB);
    check("sb_rdata", rdata, 32'h00008899);

    access(1'b1, 3'd2, 32'h12, 32'hFFFFBEEF, lat, nre, nwe);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_mem", mem[4], 32'hBEEFAABB);

    access(1'b1, 3'd0, 32'h14, 32'hDEADBEEF, lat, nre, nwe);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_re", 32'(nre), 32'd0);
    check("sw_mem", mem[5], 32'hDEADBEEF);
    load("lw", 3'd0, 32'h14, 32'hDEADBEEF);

    access(1'b0, 3'd1, 32'h11, 32'h0, lat, nre, nwe);
    check("mis_err", 32'(addr_err), 32'd1);
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_strobes", 32'(nre + nwe), 32'd0);
    check("mis_rdata", rdata, 32'hDEADBEEF);

    access(1'b0, 3'd6, 32'h10, 32'h0, lat, nre, nwe);
    check("ill_err", 32'(addr_err), 32'd1);
    check("ill_strobes", 32'(nre + nwe), 32'd0);

    load("lw_clr", 3'd0, 32'h10, 32'hBEEFAABB);

    // Reset in the WR state of a byte store.
    @(negedge clk);
    we = 1'b1; op = 3'd3; addr = 32'h13; wdata = 32'h000000CC; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("wr_active", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_re", 32'(mem_re), 32'd0);
    check("arst_err", 32'(addr_err), 32'd0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_maddr", 32'(mem_addr), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("arst_mem", mem[4], 32'hBEEFAABB);
    load("post_rst", 3'd0, 32'h10, 32'hBEEFAABB);

    // Continuous req with alternating sw/lw; inputs scrambled while busy.
    s_we[0] = 1'b1; s_addr[0] = 32'h20; s_data[0] = 32'h11112222;
    s_we[1] = 1'b0; s_addr[1] = 32'h20; s_data[1] = 32'h0;
    s_we[2] = 1'b1; s_addr[2] = 32'h24; s_data[2] = 32'h33334444;
    s_we[3] = 1'b0; s_addr[3] = 32'h24; s_data[3] = 32'h0;
    @(negedge clk);
    idx = 0; prev_done = 0;
    we = s_we[0]; op = 3'd0; addr = s_addr[0]; wdata = s_data[0]; req = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("str_single_pulse", 32'(prev_done), 32'd0);
        check("str_err", 32'(addr_err), 32'd0);
        if (!s_we[idx]) check("str_rdata", rdata, s_data[idx-1]);
        idx++;
        if (idx == 4) begin
          req = 1'b0;
          break;
        end
        we = s_we[idx]; op = 3'd0; addr = s_addr[idx]; wdata = s_data[idx];
      end else if (busy) begin
        we = ~we; op = 3'd5; addr = 32'h31; wdata = 32'hFFFFFFFF;
      end
      prev_done = int'(done);
    end
    check("str_count", 32'(idx), 32'd4);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("str_extra_done", 32'(extra), 32'd0);
    check("str_mem0", mem[8], 32'h11112222);
    check("str_mem1", mem[9], 32'h33334444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
